// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and timing constants for the neuron layer sequencer.
// A neuron costs one clear, N accumulate, one settle and one capture cycle.
package neuron_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StAccum   = 3'd2,
        StSettle  = 3'd3,
        StCapture = 3'd4,
        StDone    = 3'd5
    } state_e;

    localparam int unsigned NeuronOverhead = 3;

    function automatic int unsigned neuron_cycles(input int unsigned n);
        return n + NeuronOverhead;
    endfunction

endpackage

// File: rtl/offset_counter.sv
// Loadable up-counter that saturates at Last and flags the terminal count.
module offset_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Last  = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             last_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    assign last_o = (cnt_q == Width'(Last));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences M neurons through one shared MAC datapath and collects their results.
// All control outputs are registered decodes of the next state.
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter  int unsigned N     = 10,
    parameter  int unsigned DW    = 8,
    parameter  int unsigned M     = 4,
    // Index widths never drop to zero so N=1 / M=1 still elaborate
    localparam int unsigned OffW  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned NselW = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              hidden_mode_i,
    input  logic [DW-1:0]     dp_result_i,
    output logic [OffW-1:0]   dp_offset_o,
    output logic              dp_ld_o,
    output logic              dp_clr_o,
    output logic              dp_ready_o,
    output logic              dp_hidden_o,
    output logic [NselW-1:0]  neuron_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DW*M-1:0]   out_vec_o
);

    state_e            state_d, state_q;
    logic              hidden_d, hidden_q;
    logic [DW*M-1:0]   out_vec_d, out_vec_q;
    logic              off_last, nsel_last;
    logic              dp_ld_q, dp_clr_q, dp_ready_q, dp_hidden_q, busy_q, done_q;

    offset_counter #(
        .Width (OffW),
        .Last  (N - 1)
    ) u_offset (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != StAccum),
        .inc_i  (state_q == StAccum),
        .cnt_o  (dp_offset_o),
        .last_o (off_last)
    );

    offset_counter #(
        .Width (NselW),
        .Last  (M - 1)
    ) u_neuron (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == StIdle),
        .inc_i  (state_q == StCapture),
        .cnt_o  (neuron_sel_o),
        .last_o (nsel_last)
    );

    always_comb begin
        state_d  = state_q;
        hidden_d = hidden_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StClear;
                    hidden_d = hidden_mode_i;
                end
            end
            StClear:   state_d = StAccum;
            StAccum:   if (off_last) state_d = StSettle;
            StSettle:  state_d = StCapture;
            StCapture: state_d = nsel_last ? StDone : StClear;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        out_vec_d = out_vec_q;
        for (int k = 0; k < int'(M); k++) begin
            if (state_q == StCapture && neuron_sel_o == NselW'(k)) begin
                out_vec_d[DW*k +: DW] = dp_result_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            hidden_q    <= 1'b0;
            out_vec_q   <= '0;
            dp_ld_q     <= 1'b0;
            dp_clr_q    <= 1'b0;
            dp_ready_q  <= 1'b0;
            dp_hidden_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hidden_q    <= hidden_d;
            out_vec_q   <= out_vec_d;
            dp_ld_q     <= (state_d == StAccum);
            dp_clr_q    <= (state_d == StClear);
            dp_ready_q  <= (state_d == StSettle) || (state_d == StCapture);
            dp_hidden_q <= (state_d != StIdle) && hidden_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
        end
    end

    assign dp_ld_o     = dp_ld_q;
    assign dp_clr_o    = dp_clr_q;
    assign dp_ready_o  = dp_ready_q;
    assign dp_hidden_o = dp_hidden_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_vec_o   = out_vec_q;

endmodule
